control_pipe_unit: RTL and testbench
====================================

CONTROL_PIPE_UNIT -- requirements
Module: control_pipe_unit

Interface
REQ-001 Parameter ALUC_W, default 3, width of ALU control field (>=3).
REQ-002 Parameter RA_W, default 5, register-address width.
REQ-003 Parameter CNT_W, default 16, retire-counter width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 valid_d  in  1  decode-stage instruction valid.
REQ-007 op, func3, func7  in  7/3/7  decode-stage instruction fields.
REQ-008 rs1_d, rs2_d, rd_d  in  RA_W each  decode-stage register addresses.
REQ-009 hold  in  1  external freeze of all pipeline registers.
REQ-010 flush  in  1  branch-taken kill of the instruction entering EX.
REQ-011 ImmSrc_d  out  2  combinational immediate-format select for decode.
REQ-012 illegal_d  out  1  combinational: valid_d and opcode unsupported.
REQ-013 stall_d  out  1  combinational load-use stall request to IF/ID.
REQ-014 EX bundle out: valid_e, RegWrite_e, MemWrite_e, ResultSrc_e, ALUSrc_e, Branch_e (1 each), ALUControl_e (ALUC_W), rd_e (RA_W).
REQ-015 MEM bundle out: valid_m, RegWrite_m, MemWrite_m, ResultSrc_m (1 each), rd_m (RA_W).
REQ-016 WB bundle out: valid_w, RegWrite_w, ResultSrc_w (1 each), rd_w (RA_W).
REQ-017 retire_cnt  out  CNT_W  count of instructions leaving WB.

Function
REQ-018 Main decode SHALL be: 0110011 R: RegWrite=1, ALUOp=10; 0010011 I-ALU: RegWrite=1, ALUSrc=1, ImmSrc=00, ALUOp=10; 0000011 load: RegWrite=1, ALUSrc=1, ResultSrc=1, ImmSrc=00, ALUOp=00; 0100011 store: MemWrite=1, ALUSrc=1, ImmSrc=01, ALUOp=00; 1100011 branch: Branch=1, ImmSrc=10, ALUOp=01; unlisted signals 0.
REQ-019 Unsupported opcode SHALL decode all controls to 0 and set illegal_d when valid_d=1; it still occupies a pipeline slot with valid=1 and retires.
REQ-020 ALU decode SHALL be: ALUOp 00 -> 000 (add); 01 -> 001 (sub); 10 with func3 000 -> 001 if op[5]&func7[5] else 000; 010 -> 101; 110 -> 011; 111 -> 010; other func3 -> 000; result zero-extended to ALUC_W.
REQ-021 Latency: decoded controls SHALL appear on EX bundle 1 cycle, MEM 2 cycles, WB 3 cycles after the decode cycle.
REQ-022 Bubble = valid 0, all controls 0, rd 0.
REQ-023 stall_d SHALL be 1 when valid_d & valid_e & ResultSrc_e & RegWrite_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d); stores and branches check both sources, other opcodes too (conservative).
REQ-024 Per-edge EX-register priority: hold (keep) > flush (bubble) > stall_d (bubble) > load decode (valid_e = valid_d; controls forced 0 when valid_d=0).
REQ-025 MEM and WB registers SHALL shift from previous stage unless hold=1; flush and stall_d do not affect them.
REQ-026 hold=1 SHALL freeze every register including retire_cnt; stall_d is still computed from held EX state.
REQ-027 retire_cnt SHALL increment by 1 on each edge with valid_w=1 and hold=0, wrapping from 2^CNT_W-1 to 0.
REQ-028 flush and stall_d asserted together SHALL produce a single bubble.

Reset
REQ-029 rst=0 SHALL asynchronously clear all EX/MEM/WB outputs and retire_cnt to 0, regardless of clk, hold, or in-flight instructions.
REQ-030 First rising edge after rst returns to 1 SHALL behave as a normal cycle; in-flight instructions at reset are lost and not counted.

Verification
REQ-031 SUB (op 0110011, func7 0100000, func3 000, rd 3), valid_d=1 -> next cycle RegWrite_e=1, ALUControl_e=001, ALUSrc_e=0, rd_e=3; RegWrite_w=1, rd_w=3 three cycles later; retire_cnt +1 one cycle after that.
REQ-032 lw rd=5 followed by add rs1=5 -> stall_d=1 for exactly one cycle; bubble in EX (valid_e=0); add enters EX the following cycle with ALUControl_e=000.
REQ-033 beq in EX with flush=1 while sw is decoded -> next cycle valid_e=0, MemWrite_e=0; beq proceeds to MEM with Branch dropped, valid_m=1.
REQ-034 hold=1 for 4 cycles mid-stream -> all bundles and retire_cnt unchanged; resume exact sequence after release.
REQ-035 op 1111111, valid_d=1 -> illegal_d=1, ImmSrc_d=00, EX bundle all-zero controls with valid_e=1.
REQ-036 CNT_W=2, retire 5 instructions -> retire_cnt 1,2,3,0,1; assert rst=0 mid-stream -> all outputs 0 immediately, before next clk edge.

Source files
------------

// File: rtl/control_pipe_unit_if.sv
// Decode-side inputs and EX/MEM/WB control bundles of control_pipe_unit.
// The master side issues instructions; the slave side is the control pipeline.
interface control_pipe_unit_if #(
    parameter int ALUC_W = 3,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 16
);
    logic              valid_d;
    logic [6:0]        op;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [RA_W-1:0]   rs1_d;
    logic [RA_W-1:0]   rs2_d;
    logic [RA_W-1:0]   rd_d;
    logic              hold;
    logic              flush;
    logic [1:0]        ImmSrc_d;
    logic              illegal_d;
    logic              stall_d;
    logic              valid_e;
    logic              RegWrite_e;
    logic              MemWrite_e;
    logic              ResultSrc_e;
    logic              ALUSrc_e;
    logic              Branch_e;
    logic [ALUC_W-1:0] ALUControl_e;
    logic [RA_W-1:0]   rd_e;
    logic              valid_m;
    logic              RegWrite_m;
    logic              MemWrite_m;
    logic              ResultSrc_m;
    logic [RA_W-1:0]   rd_m;
    logic              valid_w;
    logic              RegWrite_w;
    logic              ResultSrc_w;
    logic [RA_W-1:0]   rd_w;
    logic [CNT_W-1:0]  retire_cnt;

    modport master (
        output valid_d, op, func3, func7, rs1_d, rs2_d, rd_d, hold, flush,
        input  ImmSrc_d, illegal_d, stall_d,
        input  valid_e, RegWrite_e, MemWrite_e, ResultSrc_e, ALUSrc_e, Branch_e, ALUControl_e, rd_e,
        input  valid_m, RegWrite_m, MemWrite_m, ResultSrc_m, rd_m,
        input  valid_w, RegWrite_w, ResultSrc_w, rd_w, retire_cnt
    );

    modport slave (
        input  valid_d, op, func3, func7, rs1_d, rs2_d, rd_d, hold, flush,
        output ImmSrc_d, illegal_d, stall_d,
        output valid_e, RegWrite_e, MemWrite_e, ResultSrc_e, ALUSrc_e, Branch_e, ALUControl_e, rd_e,
        output valid_m, RegWrite_m, MemWrite_m, ResultSrc_m, rd_m,
        output valid_w, RegWrite_w, ResultSrc_w, rd_w, retire_cnt
    );
endinterface

// File: rtl/control_pipe_unit.sv
// Main/ALU decode for a 5-stage RISC-V subset, carrying control through EX/MEM/WB
// with load-use stall detection, branch flush, global hold and a retire counter.
module control_pipe_unit #(
    parameter int ALUC_W = 3,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 16
) (
    input logic              clk,
    input logic              rst,
    control_pipe_unit_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_write;
        logic              result_src;
        logic              alu_src;
        logic              branch;
        logic [ALUC_W-1:0] alu_ctrl;
        logic [RA_W-1:0]   rd;
    } ex_t;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_write;
        logic            result_src;
        logic [RA_W-1:0] rd;
    } mem_t;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            result_src;
        logic [RA_W-1:0] rd;
    } wb_t;

    function automatic logic [2:0] alu_decode(input logic [1:0] alu_op,
                                              input logic [2:0] f3,
                                              input logic       sub_bit);
        case (alu_op)
            2'b00:   return 3'b000;
            2'b01:   return 3'b001;
            2'b10: begin
                case (f3)
                    3'b000:  return sub_bit ? 3'b001 : 3'b000;
                    3'b010:  return 3'b101;
                    3'b110:  return 3'b011;
                    3'b111:  return 3'b010;
                    default: return 3'b000;
                endcase
            end
            default: return 3'b000;
        endcase
    endfunction

    logic              reg_write_s, mem_write_s, result_src_s, alu_src_s, branch_s;
    logic              supported_s, stall_s;
    logic [1:0]        imm_src_s, alu_op_s;
    logic [ALUC_W-1:0] alu_ctrl_s;
    ex_t               ex_dec_s, ex_r;
    mem_t              mem_r;
    wb_t               wb_r;
    logic [CNT_W-1:0]  cnt_r;

    // Main opcode decode; unsupported opcodes leave every control at zero.
    always_comb begin
        reg_write_s  = 1'b0;
        mem_write_s  = 1'b0;
        result_src_s = 1'b0;
        alu_src_s    = 1'b0;
        branch_s     = 1'b0;
        imm_src_s    = 2'b00;
        alu_op_s     = 2'b00;
        supported_s  = 1'b1;
        case (bus.op)
            7'b0110011: begin reg_write_s = 1'b1; alu_op_s = 2'b10; end
            7'b0010011: begin reg_write_s = 1'b1; alu_src_s = 1'b1; alu_op_s = 2'b10; end
            7'b0000011: begin reg_write_s = 1'b1; alu_src_s = 1'b1; result_src_s = 1'b1; end
            7'b0100011: begin mem_write_s = 1'b1; alu_src_s = 1'b1; imm_src_s = 2'b01; end
            7'b1100011: begin branch_s = 1'b1; imm_src_s = 2'b10; alu_op_s = 2'b01; end
            default:    supported_s = 1'b0;
        endcase
    end

    assign alu_ctrl_s = ALUC_W'(alu_decode(alu_op_s, bus.func3, bus.op[5] & bus.func7[5]));

    // Candidate EX contents; an empty decode slot becomes a clean bubble.
    always_comb begin
        ex_dec_s = '0;
        if (bus.valid_d) begin
            ex_dec_s.valid      = 1'b1;
            ex_dec_s.reg_write  = reg_write_s;
            ex_dec_s.mem_write  = mem_write_s;
            ex_dec_s.result_src = result_src_s;
            ex_dec_s.alu_src    = alu_src_s;
            ex_dec_s.branch     = branch_s;
            ex_dec_s.alu_ctrl   = alu_ctrl_s;
            ex_dec_s.rd         = bus.rd_d;
        end else begin
            ex_dec_s = '0;
        end
    end

    // Both sources are compared for every opcode: a false stall only costs a cycle.
    assign stall_s = bus.valid_d & ex_r.valid & ex_r.result_src & ex_r.reg_write
                   & (ex_r.rd != {RA_W{1'b0}})
                   & ((ex_r.rd == bus.rs1_d) | (ex_r.rd == bus.rs2_d));

    // EX register: hold keeps, flush or stall inserts a bubble, otherwise load decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_r <= '0;
        end else if (bus.hold) begin
            ex_r <= ex_r;
        end else if (bus.flush || stall_s) begin
            ex_r <= '0;
        end else begin
            ex_r <= ex_dec_s;
        end
    end

    // MEM and WB registers shift unconditionally except under hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_r <= '0;
            wb_r  <= '0;
        end else if (!bus.hold) begin
            mem_r.valid      <= ex_r.valid;
            mem_r.reg_write  <= ex_r.reg_write;
            mem_r.mem_write  <= ex_r.mem_write;
            mem_r.result_src <= ex_r.result_src;
            mem_r.rd         <= ex_r.rd;
            wb_r.valid       <= mem_r.valid;
            wb_r.reg_write   <= mem_r.reg_write;
            wb_r.result_src  <= mem_r.result_src;
            wb_r.rd          <= mem_r.rd;
        end else begin
            mem_r <= mem_r;
            wb_r  <= wb_r;
        end
    end

    // Retire counter: one per valid WB slot leaving the pipe, wrapping naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!bus.hold && wb_r.valid) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bus.ImmSrc_d     = imm_src_s;
    assign bus.illegal_d    = bus.valid_d & ~supported_s;
    assign bus.stall_d      = stall_s;
    assign bus.valid_e      = ex_r.valid;
    assign bus.RegWrite_e   = ex_r.reg_write;
    assign bus.MemWrite_e   = ex_r.mem_write;
    assign bus.ResultSrc_e  = ex_r.result_src;
    assign bus.ALUSrc_e     = ex_r.alu_src;
    assign bus.Branch_e     = ex_r.branch;
    assign bus.ALUControl_e = ex_r.alu_ctrl;
    assign bus.rd_e         = ex_r.rd;
    assign bus.valid_m      = mem_r.valid;
    assign bus.RegWrite_m   = mem_r.reg_write;
    assign bus.MemWrite_m   = mem_r.mem_write;
    assign bus.ResultSrc_m  = mem_r.result_src;
    assign bus.rd_m         = mem_r.rd;
    assign bus.valid_w      = wb_r.valid;
    assign bus.RegWrite_w   = wb_r.reg_write;
    assign bus.ResultSrc_w  = wb_r.result_src;
    assign bus.rd_w         = wb_r.rd;
    assign bus.retire_cnt   = cnt_r;
endmodule

// File: tb/tb_control_pipe_unit.sv
// Scenario bench for control_pipe_unit: a queue of expected WB retirements is filled
// as instructions enter EX and drained as they leave WB; per-scenario tasks check bundles.
module tb_control_pipe_unit;
    localparam int ALUC_W = 3;
    localparam int RA_W   = 5;
    localparam int CNT_W  = 2;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_XX = 7'b1111111;

    typedef struct packed {
        logic [RA_W-1:0] rd;
        logic            rw;
        logic            rs;
    } wb_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    control_pipe_unit_if #(.ALUC_W(ALUC_W), .RA_W(RA_W), .CNT_W(CNT_W)) bus ();
    control_pipe_unit #(.ALUC_W(ALUC_W), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wb_exp_t         exp_q[$];
    int              checks = 0;
    int              passed = 0;
    int              cnt_model = 0;
    logic            m_ex_valid, m_ex_load;
    logic [RA_W-1:0] m_ex_rd;

    function automatic logic [13:0] ex_vec();
        return {bus.valid_e, bus.RegWrite_e, bus.MemWrite_e, bus.ResultSrc_e,
                bus.ALUSrc_e, bus.Branch_e, bus.ALUControl_e, bus.rd_e};
    endfunction
    function automatic logic [8:0] mem_vec();
        return {bus.valid_m, bus.RegWrite_m, bus.MemWrite_m, bus.ResultSrc_m, bus.rd_m};
    endfunction
    function automatic logic [7:0] wb_vec();
        return {bus.valid_w, bus.RegWrite_w, bus.ResultSrc_w, bus.rd_w};
    endfunction
    function automatic logic is_rw(input logic [6:0] o);
        return (o == OP_R) || (o == OP_I) || (o == OP_LD);
    endfunction

    task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [RA_W-1:0] a,
                         input logic [RA_W-1:0] b, input logic [RA_W-1:0] d);
        bus.valid_d = v; bus.op = o; bus.func3 = f3; bus.func7 = f7;
        bus.rs1_d = a; bus.rs2_d = b; bus.rd_d = d;
    endtask

    task automatic idle();
        drive(1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        cnt_model  = 0;
        m_ex_valid = 1'b0;
        m_ex_load  = 1'b0;
        m_ex_rd    = '0;
    endtask

    // Scoreboard pop: whatever sits valid in WB with hold low retires at the coming edge.
    task automatic sb_retire();
        wb_exp_t e;
        if (bus.valid_w === 1'b1 && bus.hold === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_underflow: rd_w=%0d retired, nothing expected", bus.rd_w);
            end else begin
                e = exp_q.pop_front();
                if ({bus.rd_w, bus.RegWrite_w, bus.ResultSrc_w} !== e)
                    $display("FAIL sb_wb: got rd=%0d rw=%0b rs=%0b want rd=%0d rw=%0b rs=%0b",
                             bus.rd_w, bus.RegWrite_w, bus.ResultSrc_w, e.rd, e.rw, e.rs);
                else passed++;
            end
            cnt_model++;
        end
    endtask

    // Scoreboard push: predicts which decode slot is accepted into EX at the coming edge.
    task automatic model_edge();
        logic stall_m;
        if (bus.hold !== 1'b1) begin
            stall_m = bus.valid_d && m_ex_valid && m_ex_load && (m_ex_rd != 5'd0)
                      && (m_ex_rd == bus.rs1_d || m_ex_rd == bus.rs2_d);
            if (bus.flush || stall_m) begin
                m_ex_valid = 1'b0; m_ex_load = 1'b0; m_ex_rd = '0;
            end else begin
                m_ex_valid = bus.valid_d;
                m_ex_load  = bus.valid_d && (bus.op == OP_LD);
                m_ex_rd    = bus.valid_d ? bus.rd_d : 5'd0;
                if (bus.valid_d) exp_q.push_back({bus.rd_d, is_rw(bus.op), bus.op == OP_LD});
            end
        end
    endtask

    task automatic cycle();
        #1;
        sb_retire();
        model_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        idle();
        repeat (4) cycle();
    endtask

    task automatic test_reset();
        bus.hold = 1'b1; bus.flush = 1'b0; idle();
        #1 rst = 1'b0;
        @(posedge clk); #2;
        checks++;
        if ({ex_vec(), mem_vec(), wb_vec(), bus.retire_cnt} !== 33'd0)
            $display("FAIL reset_state: got %h want 0", {ex_vec(), mem_vec(), wb_vec(), bus.retire_cnt});
        else passed++;
        model_reset();
        bus.hold = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [2:0]      f3s [5] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b010};
        logic [6:0]      f7s [5] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00};
        logic [2:0]      aluc[5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
        logic [CNT_W-1:0] seq[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int n = 1; n <= 8; n++) begin
            if (n <= 5) drive(1'b1, OP_R, f3s[n-1], f7s[n-1], 5'(n + 10), 5'(n + 20), 5'(n));
            else idle();
            cycle();
            if (n <= 5) begin
                checks++;
                if (ex_vec() !== {6'b110000, aluc[n-1], 5'(n)})
                    $display("FAIL b2b_ex%0d: got %h want %h", n, ex_vec(), {6'b110000, aluc[n-1], 5'(n)});
                else passed++;
            end
            if (n >= 4) begin
                checks++;
                if (bus.retire_cnt !== seq[n-4])
                    $display("FAIL b2b_cnt%0d: got %0d want %0d", n, bus.retire_cnt, seq[n-4]);
                else passed++;
            end
        end
    endtask

    task automatic test_sub();
        logic [CNT_W-1:0] c_exp;
        c_exp = CNT_W'(cnt_model + 1);
        drive(1'b1, OP_R, 3'b000, 7'b0100000, 5'd1, 5'd2, 5'd3);
        cycle();
        checks++;
        if (ex_vec() !== {6'b110000, 3'b001, 5'd3})
            $display("FAIL sub_ex: got %h want %h", ex_vec(), {6'b110000, 3'b001, 5'd3});
        else passed++;
        idle();
        cycle(); cycle();
        checks++;
        if (wb_vec() !== {3'b110, 5'd3})
            $display("FAIL sub_wb: got %h want %h", wb_vec(), {3'b110, 5'd3});
        else passed++;
        cycle();
        checks++;
        if (bus.retire_cnt !== c_exp)
            $display("FAIL sub_cnt: got %0d want %0d", bus.retire_cnt, c_exp);
        else passed++;
        drain();
    endtask

    task automatic test_load_use();
        drive(1'b1, OP_LD, 3'b010, 7'd0, 5'd1, 5'd0, 5'd5);
        #1;
        checks++;
        if ({bus.stall_d, bus.ImmSrc_d} !== 3'b000)
            $display("FAIL lw_decode: got %b want 000", {bus.stall_d, bus.ImmSrc_d});
        else passed++;
        cycle();
        drive(1'b1, OP_R, 3'b000, 7'd0, 5'd5, 5'd6, 5'd7);
        #1;
        checks++;
        if (bus.stall_d !== 1'b1) $display("FAIL lu_stall: got %b want 1", bus.stall_d);
        else passed++;
        cycle();
        checks++;
        if ({ex_vec(), bus.stall_d} !== 15'd0)
            $display("FAIL lu_bubble: got %h want 0", {ex_vec(), bus.stall_d});
        else passed++;
        cycle();
        checks++;
        if (ex_vec() !== {6'b110000, 3'b000, 5'd7})
            $display("FAIL lu_add_ex: got %h want %h", ex_vec(), {6'b110000, 3'b000, 5'd7});
        else passed++;
        drain();
    endtask

    task automatic test_flush();
        drive(1'b1, OP_BR, 3'b000, 7'd0, 5'd1, 5'd2, 5'd0);
        #1;
        checks++;
        if (bus.ImmSrc_d !== 2'b10) $display("FAIL beq_imm: got %b want 10", bus.ImmSrc_d);
        else passed++;
        cycle();
        checks++;
        if (ex_vec() !== {6'b100001, 3'b001, 5'd0})
            $display("FAIL beq_ex: got %h want %h", ex_vec(), {6'b100001, 3'b001, 5'd0});
        else passed++;
        drive(1'b1, OP_ST, 3'b010, 7'd0, 5'd1, 5'd4, 5'd0);
        bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.ImmSrc_d !== 2'b01) $display("FAIL sw_imm: got %b want 01", bus.ImmSrc_d);
        else passed++;
        cycle();
        bus.flush = 1'b0;
        checks++;
        if ({ex_vec(), mem_vec()} !== {14'd0, 4'b1000, 5'd0})
            $display("FAIL flush: got %h want %h", {ex_vec(), mem_vec()}, {14'd0, 4'b1000, 5'd0});
        else passed++;
        drain();
    endtask

    task automatic test_hold();
        logic [32:0] frz;
        drive(1'b1, OP_I, 3'b000, 7'd0, 5'd1, 5'd0, 5'd8);  cycle();
        drive(1'b1, OP_R, 3'b000, 7'd0, 5'd1, 5'd2, 5'd9);  cycle();
        drive(1'b1, OP_R, 3'b010, 7'd0, 5'd1, 5'd2, 5'd11); cycle();
        drive(1'b1, OP_I, 3'b110, 7'd0, 5'd1, 5'd0, 5'd10);
        bus.hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            frz = {6'b110000, 3'b101, 5'd11, 4'b1100, 5'd9, 3'b110, 5'd8, CNT_W'(cnt_model)};
            checks++;
            if ({ex_vec(), mem_vec(), wb_vec(), bus.retire_cnt} !== frz)
                $display("FAIL hold%0d: got %h want %h", k, {ex_vec(), mem_vec(), wb_vec(), bus.retire_cnt}, frz);
            else passed++;
        end
        bus.hold = 1'b0;
        cycle();
        frz = {6'b110010, 3'b011, 5'd10, 4'b1100, 5'd11, 3'b110, 5'd9, CNT_W'(cnt_model)};
        checks++;
        if ({ex_vec(), mem_vec(), wb_vec(), bus.retire_cnt} !== frz)
            $display("FAIL hold_resume: got %h want %h", {ex_vec(), mem_vec(), wb_vec(), bus.retire_cnt}, frz);
        else passed++;
        drain();
    endtask

    task automatic test_illegal();
        drive(1'b0, OP_XX, 3'b000, 7'd0, 5'd1, 5'd2, 5'd0);
        #1;
        checks++;
        if (bus.illegal_d !== 1'b0) $display("FAIL illegal_idle: got %b want 0", bus.illegal_d);
        else passed++;
        bus.valid_d = 1'b1;
        #1;
        checks++;
        if ({bus.illegal_d, bus.ImmSrc_d} !== 3'b100)
            $display("FAIL illegal_d: got %b want 100", {bus.illegal_d, bus.ImmSrc_d});
        else passed++;
        cycle();
        checks++;
        if (ex_vec() !== {6'b100000, 3'b000, 5'd0})
            $display("FAIL illegal_ex: got %h want %h", ex_vec(), {6'b100000, 3'b000, 5'd0});
        else passed++;
        drain();
    endtask

    task automatic test_async_reset();
        drive(1'b1, OP_LD, 3'b010, 7'd0, 5'd1, 5'd0, 5'd6); cycle();
        drive(1'b1, OP_R, 3'b000, 7'd0, 5'd1, 5'd2, 5'd7);  cycle();
        idle(); cycle();
        rst = 1'b0;
        #1;
        checks++;
        if ({ex_vec(), mem_vec(), wb_vec(), bus.retire_cnt} !== 33'd0)
            $display("FAIL async_rst: got %h want 0", {ex_vec(), mem_vec(), wb_vec(), bus.retire_cnt});
        else passed++;
        model_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        drive(1'b1, OP_I, 3'b000, 7'd0, 5'd1, 5'd0, 5'd12);
        cycle();
        checks++;
        if (ex_vec() !== {6'b110010, 3'b000, 5'd12})
            $display("FAIL post_rst_ex: got %h want %h", ex_vec(), {6'b110010, 3'b000, 5'd12});
        else passed++;
        drain();
        checks++;
        if (bus.retire_cnt !== 2'd1) $display("FAIL post_rst_cnt: got %0d want 1", bus.retire_cnt);
        else passed++;
    endtask

    initial begin
        bus.hold = 1'b0; bus.flush = 1'b0; idle();
        model_reset();
        test_reset();
        test_back_to_back();
        test_sub();
        test_load_use();
        test_flush();
        test_hold();
        test_illegal();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
